// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel fixed-priority/round-robin arbiter in front of a single byte-serial memory controller
//   clk_in, rst_n_in           clock, asynchronous active-low reset
//   rdy_in                     global stall (low freezes all state, blocks accepts)
//   flush_in                   pipeline flush, cancels masked in-flight reads
//   req_* / req_accept         per-channel request bundle and one-hot combinational accept
//   resp_valid / resp_data     one-hot completion pulse and read result
//   mc_* / mc_ready, mc_result registered request to the controller and its completion
module mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int ARB_MODE = 1,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = {NUM_CH{1'b1}}
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_wr,
    input  logic [3*NUM_CH-1:0]      req_len,
    input  logic [ADDR_W*NUM_CH-1:0] req_addr,
    input  logic [32*NUM_CH-1:0]     req_value,
    output logic [NUM_CH-1:0]        req_accept,
    output logic [NUM_CH-1:0]        resp_valid,
    output logic [31:0]              resp_data,
    output logic                     mc_valid,
    output logic                     mc_wr,
    output logic [2:0]               mc_len,
    output logic [ADDR_W-1:0]        mc_addr,
    output logic [31:0]              mc_value,
    input  logic                     mc_ready,
    input  logic [31:0]              mc_result
);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
    state_t state, state_nx;
    logic [IW-1:0] grant, rr, pick, cand;
    logic [NUM_CH-1:0] eligible;
    logic [2:0] lenv;
    logic found, accept_go, rd_masked, discard;
    int idx;
    // Search starts just past the last grant in round-robin mode, at 0 in fixed mode
    always_comb begin
        eligible = req_valid & ~(flush_in ? FLUSH_MASK & ~req_wr : '0);
        found = 1'b0;
        pick = '0;
        idx = 0;
        cand = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ((ARB_MODE != 0 ? int'(rr) + 1 : 0) + i) % NUM_CH;
            cand = IW'(idx);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick = cand;
            end
        end
    end
    assign lenv = req_len[pick*3 +: 3];
    always_comb begin
        accept_go = rdy_in && state == IDLE && found;
        rd_masked = !mc_wr && FLUSH_MASK[grant];
        req_accept = '0;
        req_accept[pick] = accept_go;
        // Gated by rdy_in so a stall in RESP cannot stretch the pulse
        resp_valid = '0;
        resp_valid[grant] = rdy_in && state == RESP && !discard && !(flush_in && rd_masked);
        state_nx = state == IDLE ? (found ? ISSUE : IDLE) :
                   state == ISSUE ? BUSY :
                   state == BUSY ? (mc_ready ? RESP : BUSY) : IDLE;
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            grant <= '0;
            rr <= IW'(NUM_CH - 1);
            mc_valid <= 1'b0;
            mc_wr <= 1'b0;
            mc_len <= '0;
            mc_addr <= '0;
            mc_value <= '0;
            resp_data <= '0;
            discard <= 1'b0;
        end else if (rdy_in) begin
            state <= state_nx;
            mc_valid <= accept_go;
            if (accept_go) begin
                grant <= pick;
                rr <= pick;
                mc_wr <= req_wr[pick];
                mc_len <= lenv > 3'd2 ? 3'd2 : lenv;
                mc_addr <= req_addr[pick*ADDR_W +: ADDR_W];
                mc_value <= req_value[pick*32 +: 32];
            end
            if (state == BUSY && mc_ready)
                resp_data <= mc_wr ? '0 : mc_result;
            // The controller cannot abort, so a flushed read still completes but its response is dropped
            discard <= state == RESP ? 1'b0 :
                       discard || ((state == ISSUE || state == BUSY) && flush_in && rd_masked);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk_in = 1'b0;
    logic rst_n_in, rdy_in, flush_in, mc_ready, mc_ready3;
    logic [1:0] req_valid, req_wr, req_accept, resp_valid;
    logic [5:0] req_len;
    logic [63:0] req_addr, req_value;
    logic [31:0] resp_data, mc_addr, mc_value, mc_result;
    logic mc_valid, mc_wr;
    logic [2:0] mc_len;
    logic [2:0] r3_valid, r3_wr, acc_rr, acc_fx, rv_rr, rv_fx;
    logic [8:0] r3_len;
    logic [95:0] r3_addr, r3_value;
    logic [31:0] rd_rr, rd_fx, ma_rr, ma_fx, mval_rr, mval_fx, mc_result3;
    logic mv_rr, mv_fx, mw_rr, mw_fx;
    logic [2:0] ml_rr, ml_fx;
    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .ARB_MODE(1)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .req_valid(req_valid), .req_wr(req_wr), .req_len(req_len), .req_addr(req_addr),
        .req_value(req_value), .req_accept(req_accept), .resp_valid(resp_valid),
        .resp_data(resp_data), .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_len(mc_len),
        .mc_addr(mc_addr), .mc_value(mc_value), .mc_ready(mc_ready), .mc_result(mc_result)
    );

    mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .ARB_MODE(1)) dut_rr (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(1'b0),
        .req_valid(r3_valid), .req_wr(r3_wr), .req_len(r3_len), .req_addr(r3_addr),
        .req_value(r3_value), .req_accept(acc_rr), .resp_valid(rv_rr),
        .resp_data(rd_rr), .mc_valid(mv_rr), .mc_wr(mw_rr), .mc_len(ml_rr),
        .mc_addr(ma_rr), .mc_value(mval_rr), .mc_ready(mc_ready3), .mc_result(mc_result3)
    );

    mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .ARB_MODE(0)) dut_fx (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(1'b0),
        .req_valid(r3_valid), .req_wr(r3_wr), .req_len(r3_len), .req_addr(r3_addr),
        .req_value(r3_value), .req_accept(acc_fx), .resp_valid(rv_fx),
        .resp_data(rd_fx), .mc_valid(mv_fx), .mc_wr(mw_fx), .mc_len(ml_fx),
        .mc_addr(ma_fx), .mc_value(mval_fx), .mc_ready(mc_ready3), .mc_result(mc_result3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [2:0] len,
                           input logic [31:0] addr, input logic [31:0] value);
        req_wr[ch] = wr;
        req_len[ch*3 +: 3] = len;
        req_addr[ch*32 +: 32] = addr;
        req_value[ch*32 +: 32] = value;
    endtask

    task automatic arb_round(input logic [2:0] er, input logic [2:0] ef);
        #1;
        chk("arb_rr_accept", acc_rr, er);
        chk("arb_fx_accept", acc_fx, ef);
        step;
        step;
        mc_ready3 = 1'b1;
        step;
        mc_ready3 = 1'b0;
        #1;
        chk("arb_rr_resp", rv_rr, er);
        chk("arb_fx_resp", rv_fx, ef);
        step;
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; mc_ready = 1'b0; mc_ready3 = 1'b0;
        mc_result = '0; mc_result3 = '0;
        req_valid = '0; req_wr = '0; req_len = '0; req_addr = '0; req_value = '0;
        r3_valid = '0; r3_wr = '0; r3_len = {3{3'd2}}; r3_value = '0;
        r3_addr = {32'h300, 32'h200, 32'h100};
        #12;
        chk("rst_mc_valid", mc_valid, 0);
        chk("rst_mc_addr", mc_addr, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        rst_n_in = 1'b1;
        step;
        // single read on ch1, mc_ready 5 cycles after mc_valid
        set_req(1, 1'b0, 3'd2, 32'h0000_1004, 32'h0);
        req_valid = 2'b10;
        #1;
        chk("rd_accept", req_accept, 2'b10);
        step;
        req_valid = '0;
        #1;
        chk("rd_mc_valid", mc_valid, 1);
        chk("rd_mc_addr", mc_addr, 32'h1004);
        chk("rd_mc_len", mc_len, 2);
        chk("rd_mc_wr", mc_wr, 0);
        step;
        chk("rd_mc_pulse", mc_valid, 0);
        repeat (4) step;
        mc_ready = 1'b1;
        mc_result = 32'hDEAD_BEEF;
        #1;
        chk("rd_no_early_resp", resp_valid, 0);
        step;
        mc_ready = 1'b0;
        #1;
        chk("rd_resp_valid", resp_valid, 2'b10);
        chk("rd_resp_data", resp_data, 32'hDEAD_BEEF);
        step;
        chk("rd_resp_pulse", resp_valid, 0);
        // store on ch0, flush during BUSY must not suppress it
        set_req(0, 1'b1, 3'd0, 32'h0003_0000, 32'hAB);
        req_valid = 2'b01;
        #1;
        chk("st_accept", req_accept, 2'b01);
        step;
        req_valid = '0;
        #1;
        chk("st_mc_wr", mc_wr, 1);
        chk("st_mc_len", mc_len, 0);
        chk("st_mc_value", mc_value, 32'hAB);
        chk("st_mc_addr", mc_addr, 32'h30000);
        step;
        flush_in = 1'b1;
        step;
        flush_in = 1'b0;
        mc_ready = 1'b1;
        mc_result = 32'h1234_5678;
        step;
        mc_ready = 1'b0;
        #1;
        chk("st_resp_valid", resp_valid, 2'b01);
        chk("st_resp_data", resp_data, 0);
        step;
        // flushed read on ch0, then ch1 read proceeds normally
        set_req(0, 1'b0, 3'd2, 32'h200, 32'h0);
        req_valid = 2'b01;
        #1;
        chk("fl_accept", req_accept, 2'b01);
        step;
        req_valid = '0;
        step;
        flush_in = 1'b1;
        step;
        flush_in = 1'b0;
        mc_ready = 1'b1;
        mc_result = 32'h55;
        step;
        mc_ready = 1'b0;
        set_req(1, 1'b0, 3'd2, 32'h204, 32'h0);
        req_valid = 2'b10;
        #1;
        chk("fl_suppressed", resp_valid, 0);
        chk("fl_resp_no_accept", req_accept, 0);
        step;
        chk("fl_next_accept", req_accept, 2'b10);
        step;
        req_valid = '0;
        #1;
        chk("fl_next_addr", mc_addr, 32'h204);
        step;
        mc_ready = 1'b1;
        mc_result = 32'h77;
        step;
        mc_ready = 1'b0;
        #1;
        chk("fl_next_resp", resp_valid, 2'b10);
        chk("fl_next_data", resp_data, 32'h77);
        step;
        // flush in IDLE blocks masked reads, not writes
        set_req(0, 1'b0, 3'd2, 32'h200, 32'h0);
        req_valid = 2'b01;
        flush_in = 1'b1;
        #1;
        chk("fl_idle_read_blocked", req_accept, 0);
        set_req(1, 1'b1, 3'd2, 32'h208, 32'h1);
        req_valid = 2'b11;
        #1;
        chk("fl_idle_write_ok", req_accept, 2'b10);
        req_valid = '0;
        req_wr = '0;
        flush_in = 1'b0;
        step;
        // stall during ISSUE with len clamp
        set_req(0, 1'b0, 3'd5, 32'h44, 32'h0);
        req_valid = 2'b01;
        #1;
        chk("stall_accept", req_accept, 2'b01);
        step;
        req_valid = '0;
        rdy_in = 1'b0;
        #1;
        chk("stall_mc_valid0", mc_valid, 1);
        chk("len_clamp", mc_len, 2);
        step;
        chk("stall_hold1", mc_valid, 1);
        step;
        chk("stall_hold2", mc_valid, 1);
        step;
        chk("stall_hold3", mc_valid, 1);
        rdy_in = 1'b1;
        step;
        chk("stall_release", mc_valid, 0);
        mc_ready = 1'b1;
        step;
        mc_ready = 1'b0;
        #1;
        chk("stall_resp", resp_valid, 2'b01);
        step;
        req_valid = 2'b10;
        rdy_in = 1'b0;
        #1;
        chk("stall_no_accept", req_accept, 0);
        rdy_in = 1'b1;
        #1;
        chk("stall_accept_back", req_accept, 2'b10);
        req_valid = '0;
        step;
        // async reset mid-BUSY drops the transaction
        set_req(1, 1'b0, 3'd2, 32'h100, 32'h0);
        req_valid = 2'b10;
        #1;
        chk("rst_tx_accept", req_accept, 2'b10);
        step;
        req_valid = '0;
        step;
        chk("rst_busy_addr", mc_addr, 32'h100);
        rst_n_in = 1'b0;
        #1;
        chk("rst_async_addr", mc_addr, 0);
        chk("rst_async_valid", mc_valid, 0);
        chk("rst_async_data", resp_data, 0);
        chk("rst_async_resp", resp_valid, 0);
        #1;
        rst_n_in = 1'b1;
        mc_ready = 1'b1;
        step;
        mc_ready = 1'b0;
        #1;
        chk("rst_no_resp1", resp_valid, 0);
        step;
        chk("rst_no_resp2", resp_valid, 0);
        chk("rst_no_issue", mc_valid, 0);
        // arbitration: 3 channels continuously valid, round-robin vs fixed priority
        r3_valid = 3'b111;
        arb_round(3'b001, 3'b001);
        arb_round(3'b010, 3'b001);
        arb_round(3'b100, 3'b001);
        arb_round(3'b001, 3'b001);
        arb_round(3'b010, 3'b001);
        r3_valid = 3'b110;
        arb_round(3'b100, 3'b010);
        r3_valid = '0;
        step;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel request arbiter between cache/LSB clients and the single byte-serial memory controller.
- Generalises the present fixed I/D front-end. Any client (icache refill, dcache/LSB load, store, later prefetch) issues a read or write of byte/half/word.
- Selects one client per transaction under fixed-priority or round-robin policy and forwards the request.
- Returns the result to the granted client. Supports flush-cancellation of in-flight reads.

Parameters:
- NUM_CH, 2, number of client channels (index 0 = highest fixed priority), 2..8
- ADDR_W, 32, address width (memory uses bits 17:0)
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- FLUSH_MASK, {NUM_CH{1'b1}}, per-channel bit: 1 = channel's reads are discarded on flush_in

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global stall; low freezes all state
- flush_in  in  1  pipeline flush (branch mispredict)
- req_valid  in  NUM_CH  per-channel request pending; held until req_accept
- req_wr  in  NUM_CH  1 = write
- req_len  in  3*NUM_CH  0 = byte, 1 = half, 2 = word
- req_addr  in  ADDR_W*NUM_CH  request address
- req_value  in  32*NUM_CH  write data
- req_accept  out  NUM_CH  one-hot, combinational; request taken this cycle
- resp_valid  out  NUM_CH  one-hot one-cycle pulse; result/completion for channel
- resp_data  out  32  read result, valid with resp_valid
- mc_valid  out  1  request strobe to memory controller (one-cycle pulse)
- mc_wr  out  1  forwarded wr
- mc_len  out  3  forwarded len
- mc_addr  out  ADDR_W  forwarded address
- mc_value  out  32  forwarded write data
- mc_ready  in  1  one-cycle pulse: transaction complete, mc_result valid
- mc_result  in  32  read data from controller

Behaviour:
- Async reset (rst_n_in low) sets:
  - state = IDLE, mc_valid = 0, mc_wr = 0, mc_len = 0, mc_addr = 0, mc_value = 0
  - resp_valid = 0, resp_data = 0
  - rr pointer = NUM_CH-1, so channel 0 is searched first
  - discard = 0
- Reset mid-transaction drops it silently; no resp_valid after release.
- rdy_in low: all registers hold; req_accept forced 0. A held mc_valid stays high until rdy_in returns.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Eligible = req_valid & ~(flush_in ? FLUSH_MASK & ~req_wr : 0).
  - If any eligible, grant is chosen:
    - ARB_MODE 0: lowest eligible index.
    - ARB_MODE 1: first eligible index searching from rr+1 modulo NUM_CH.
  - req_accept[grant] = 1 in that cycle. Latch wr/len/addr/value and grant; rr <= grant; go ISSUE.
- ISSUE: mc_valid = 1 for exactly this cycle; go BUSY.
- BUSY:
  - Wait for mc_ready.
  - On mc_ready: resp_data <= mc_result (writes: resp_data <= 0); go RESP.
  - mc_ready while IDLE or ISSUE is ignored.
- RESP:
  - resp_valid[grant] = 1 unless discard. Clear discard; go IDLE.
  - New arbitration starts the following cycle; no back-to-back issue from RESP.
- Flush:
  - flush_in in ISSUE/BUSY with latched read and FLUSH_MASK[grant] = 1 sets discard. The memory transaction still runs to completion because the controller cannot abort.
  - Writes are never discarded.
  - flush_in in RESP suppresses that cycle's resp_valid for masked reads.
- Latency: accept at cycle 0, mc_valid at cycle 1, mc_ready at cycle k ≥ 2, resp_valid at k+1. Minimum accept-to-accept is 4 cycles.
- req_len values 3..7 are clamped to 2 on mc_len.
- Clients must hold request fields stable while req_valid is high and not yet accepted. Fields after accept are don't-care.
- Only one outstanding transaction; mc_* outputs are registered and stable from ISSUE through RESP.
- NUM_CH = 1 degenerates to a pass-through with the same timing.

Test Plan:
- Reset: pulse rst_n_in low asynchronously mid-BUSY (addr 0x100) → all outputs 0 immediately; later mc_ready produces no resp_valid.
- Single read: ch1 valid, wr=0, len=2, addr=0x0000_1004; mc_ready 5 cycles after mc_valid with mc_result 0xDEADBEEF → req_accept=2'b10 at cycle 0, mc_valid cycle 1 with mc_addr 0x1004, mc_len 2, resp_valid=2'b10 with resp_data 0xDEADBEEF one cycle after mc_ready.
- Arbitration ARB_MODE=1, NUM_CH=3, all three valid continuously → grant order 0,1,2,0,1. With ARB_MODE=0 under the same stimulus → always 0 until ch0 drops.
- Store: ch0 wr=1, len=0, addr=0x30000, value=0xAB → mc_wr=1, mc_len=0, mc_value=0xAB; resp_valid[0] with resp_data 0. flush_in during BUSY does not suppress it.
- Flush read: ch0 read in BUSY, flush_in pulse, then mc_ready → no resp_valid. Next cycle ch1 read accepted normally. flush_in in IDLE with ch0 read valid → req_accept=0 that cycle.
- Stall: rdy_in low for 3 cycles during ISSUE → mc_valid stays high 4 cycles total, no state advance, req_accept 0. len=5 request → mc_len=2.
